arp_lookup_arbiter: RTL and testbench
=====================================

# arp_lookup_arbiter

Shares the single-port ARP table between two lookup requesters (port 0: UDP TX, port 1: ICMP TX) and the ARP RX update source. It serializes all table operations, turns the table's fire-and-forget lookup into a request/ack/response handshake, bounds every lookup with a timeout, and optionally asks the ARP TX path to resolve an address on a miss. It sits between the IP-layer TX paths and the ARP table.

## Interface
- P_TIMEOUT, 32: cycles to wait for table response after a lookup issue.
- P_UPD_HOLD, 16: cycles the block stays busy after issuing an update (covers the table's 8-entry scan and write).
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_req0_valid / i_req1_valid  in  1  lookup request; held high, IP stable until ready.
- i_req0_ip / i_req1_ip  in  32  IP to resolve.
- o_req0_ready / o_req1_ready  out  1  one-cycle accept pulse.
- o_rsp_valid  out  2  one-hot response pulse, bit n = requester n.
- o_rsp_mac  out  48  resolved MAC; 48'hFFFF_FFFF_FFFF on miss or timeout.
- o_rsp_hit  out  1  1 = table hit.
- i_upd_valid  in  1  update pulse from ARP RX.
- i_upd_ip, i_upd_mac  in  32 / 48  update pair.
- o_upd_drop  out  1  pulse: pending update overwritten.
- o_seek_ip / o_seek_valid  out  32 / 1  to table.
- o_updata_ip / o_updata_mac / o_updata_valid  out  32 / 48 / 1  to table.
- i_active_mac / i_active_valid  in  48 / 1  from table.
- o_arp_req_ip / o_arp_req_valid  out  32 / 1  to ARP TX (see Configuration).
- o_busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, UPD, UPD_HOLD, SEEK, WAIT, RESP.
- Update buffer: one entry (ip, mac, pending). i_upd_valid captures and sets pending. If pending is already set and not being consumed that cycle: overwrite, pulse o_upd_drop. Capture in the same cycle as consumption: new pair kept, pending stays 1, no drop.
- IDLE priority: pending update > lookups. Between lookups, round-robin pointer rr (reset 0). rr is favoured when both are valid. After a grant, rr = other port.
- IDLE→UPD: o_updata_* driven from buffer, o_updata_valid=1 for one cycle, pending cleared → UPD_HOLD.
- UPD_HOLD: counts P_UPD_HOLD cycles → IDLE.
- IDLE→SEEK (grant n): latches IP and n. In SEEK: o_reqn_ready=1, o_seek_valid=1, o_seek_ip=latched IP, all for exactly one cycle → WAIT.
- WAIT: on i_active_valid, latch i_active_mac, hit = (mac != all-ones) → RESP. On counter reaching P_TIMEOUT: mac = all-ones, hit=0 → RESP. A late i_active_valid arriving outside WAIT is ignored.
- RESP: o_rsp_valid[n]=1 for one cycle with o_rsp_mac/o_rsp_hit → IDLE.
- Reset values: all outputs 0, except o_rsp_mac = 0. State IDLE, rr=0, pending=0, counters 0. Reset mid-operation abandons the op; no response is generated.

## Timing
- Outputs registered. Request seen in IDLE at cycle t → ready+seek at t+1 → response at t+1+L+1, where L is the table latency (≤ P_TIMEOUT).
- Update: valid in IDLE at t (buffer written at t) → o_updata_valid at t+2; IDLE again at t+3+P_UPD_HOLD.
- Requests are never accepted while o_busy=1. Only one requester is acked per grant. o_rsp_* are valid only during an o_rsp_valid pulse.
- Timeout counter width: clog2(P_TIMEOUT+1). Hold counter width: clog2(P_UPD_HOLD+1). Both clear on state entry.

## Configuration
- ARP_LOOKUP_ARB_MISS_REQ_EN defined: in RESP with hit=0 (miss or timeout), o_arp_req_valid pulses for one cycle, coincident with o_rsp_valid, and o_arp_req_ip = latched IP.
- Not defined: o_arp_req_valid and o_arp_req_ip are tied to 0, and no related logic is built.

## Test plan
- Table returns 11:22:33:44:55:66 two cycles after a seek for req0 IP 192.168.1.10 → o_req0_ready one pulse, o_rsp_valid=2'b01, hit=1, MAC matches.
- req0 and req1 held valid together for two grants → port 0 is served first, then port 1; o_rsp_valid sequence 01 then 10.
- Table model never responds → o_rsp_valid pulses P_TIMEOUT+1 cycles after seek with MAC all-ones and hit=0. With macro defined, o_arp_req_valid pulses with the same IP; without it, o_arp_req_valid stays 0.
- Update and req0 both arrive in IDLE → o_updata_valid first, no ready for P_UPD_HOLD+1 cycles, then req0 is served.
- Two i_upd_valid pulses during a lookup → o_upd_drop once; only the second pair is written.
- i_rst asserted while in WAIT → next cycle IDLE, all outputs zero, no o_rsp_valid; a fresh request then completes normally.

Source files
------------

// File: rtl/arp_lookup_arbiter.sv
// arp_lookup_arbiter: shares the single-port ARP table between two lookup requesters
//   (port 0 UDP TX, port 1 ICMP TX) and the ARP RX update source, serializing all table ops.
// Latency: lookup ready+seek 1 cycle after the request is seen in IDLE, response 1 cycle after
//   the table answers (or P_TIMEOUT+1 cycles after seek); update written 2 cycles after capture.
// Backpressure: requesters hold valid until a one-cycle ready pulse; no request is accepted while
//   o_busy; the single-entry update buffer overwrites on collision and pulses o_upd_drop.
// Ports: i_req*_*/o_req*_ready lookup handshake, o_rsp_* one-hot response, i_upd_* update input,
//   o_seek_*/o_updata_*/i_active_* table side, o_arp_req_* resolve request to ARP TX.
// Optional feature: define ARP_LOOKUP_ARB_MISS_REQ_EN to raise o_arp_req_valid on a miss or timeout.
module arp_lookup_arbiter #(
  parameter int P_TIMEOUT  = 32,
  parameter int P_UPD_HOLD = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  input  logic [31:0] i_req0_ip,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [31:0] i_req1_ip,
  output logic        o_req1_ready,
  output logic [1:0]  o_rsp_valid,
  output logic [47:0] o_rsp_mac,
  output logic        o_rsp_hit,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_ip,
  input  logic [47:0] i_upd_mac,
  output logic        o_upd_drop,
  output logic [31:0] o_seek_ip,
  output logic        o_seek_valid,
  output logic [31:0] o_updata_ip,
  output logic [47:0] o_updata_mac,
  output logic        o_updata_valid,
  input  logic [47:0] i_active_mac,
  input  logic        i_active_valid,
  output logic [31:0] o_arp_req_ip,
  output logic        o_arp_req_valid,
  output logic        o_busy
);

  localparam int TW = $clog2(P_TIMEOUT + 1);
  localparam int HW = $clog2(P_UPD_HOLD + 1);
  localparam logic [47:0] MAC_NONE = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {S_IDLE, S_UPD, S_UPD_HOLD, S_SEEK, S_WAIT, S_RESP} state_t;

  state_t        state_q;
  logic          rr_q, port_q;
  logic [31:0]   ip_q;
  logic [TW-1:0] tcnt_q;
  logic [HW-1:0] hcnt_q;
  logic [47:0]   rsp_mac_q;
  logic          rsp_hit_q;
  logic [1:0]    rsp_valid_q;
  logic          ready0_q, ready1_q, seek_valid_q;
  logic          updata_valid_q;
  logic [31:0]   updata_ip_q;
  logic [47:0]   updata_mac_q;

  // single-entry update buffer
  logic          pend_q;
  logic [31:0]   pend_ip_q;
  logic [47:0]   pend_mac_q;
  logic          drop_q;

  logic upd_consume, gnt1, any_req, tmo, act_hit;

  assign upd_consume = (state_q == S_IDLE) && pend_q;
  assign any_req     = i_req0_valid | i_req1_valid;
  // rr_q = 1 favours port 1 when both requesters are valid
  assign gnt1        = i_req1_valid && (!i_req0_valid || rr_q);
  assign tmo         = (tcnt_q == TW'(P_TIMEOUT - 1));
  assign act_hit     = (i_active_mac != MAC_NONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q     <= 1'b0;
      pend_ip_q  <= '0;
      pend_mac_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= i_upd_valid && pend_q && !upd_consume;
      // a capture in the consuming cycle wins: the new pair stays pending
      if (i_upd_valid) begin
        pend_q     <= 1'b1;
        pend_ip_q  <= i_upd_ip;
        pend_mac_q <= i_upd_mac;
      end else if (upd_consume) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      rr_q           <= 1'b0;
      port_q         <= 1'b0;
      ip_q           <= '0;
      tcnt_q         <= '0;
      hcnt_q         <= '0;
      rsp_mac_q      <= '0;
      rsp_hit_q      <= 1'b0;
      rsp_valid_q    <= '0;
      ready0_q       <= 1'b0;
      ready1_q       <= 1'b0;
      seek_valid_q   <= 1'b0;
      updata_valid_q <= 1'b0;
      updata_ip_q    <= '0;
      updata_mac_q   <= '0;
    end else begin
      ready0_q       <= 1'b0;
      ready1_q       <= 1'b0;
      seek_valid_q   <= 1'b0;
      updata_valid_q <= 1'b0;
      rsp_valid_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            updata_valid_q <= 1'b1;
            updata_ip_q    <= pend_ip_q;
            updata_mac_q   <= pend_mac_q;
            state_q        <= S_UPD;
          // an update arriving this cycle will be pending next cycle and outranks lookups
          end else if (!i_upd_valid && any_req) begin
            port_q       <= gnt1;
            ip_q         <= gnt1 ? i_req1_ip : i_req0_ip;
            rr_q         <= ~gnt1;
            ready0_q     <= ~gnt1;
            ready1_q     <= gnt1;
            seek_valid_q <= 1'b1;
            state_q      <= S_SEEK;
          end
        end
        S_UPD: begin
          hcnt_q  <= '0;
          state_q <= S_UPD_HOLD;
        end
        S_UPD_HOLD: begin
          if (hcnt_q == HW'(P_UPD_HOLD - 1)) state_q <= S_IDLE;
          else                               hcnt_q  <= hcnt_q + HW'(1);
        end
        S_SEEK: begin
          tcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_active_valid || tmo) begin
            rsp_mac_q   <= i_active_valid ? i_active_mac : MAC_NONE;
            rsp_hit_q   <= i_active_valid && act_hit;
            rsp_valid_q <= port_q ? 2'b10 : 2'b01;
            state_q     <= S_RESP;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req0_ready   = ready0_q;
  assign o_req1_ready   = ready1_q;
  assign o_seek_valid   = seek_valid_q;
  assign o_seek_ip      = ip_q;
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_mac      = rsp_mac_q;
  assign o_rsp_hit      = rsp_hit_q;
  assign o_updata_valid = updata_valid_q;
  assign o_updata_ip    = updata_ip_q;
  assign o_updata_mac   = updata_mac_q;
  assign o_upd_drop     = drop_q;
  assign o_busy         = (state_q != S_IDLE);

`ifdef ARP_LOOKUP_ARB_MISS_REQ_EN
  logic arp_req_valid_q;

  // fires on the WAIT exit that produces a miss (all-ones answer or timeout)
  always_ff @(posedge i_clk) begin
    if (i_rst) arp_req_valid_q <= 1'b0;
    else       arp_req_valid_q <= (state_q == S_WAIT) && (i_active_valid || tmo) &&
                                  !(i_active_valid && act_hit);
  end

  assign o_arp_req_valid = arp_req_valid_q;
  assign o_arp_req_ip    = arp_req_valid_q ? ip_q : 32'h0;
`else
  assign o_arp_req_valid = 1'b0;
  assign o_arp_req_ip    = 32'h0;
`endif

endmodule

// File: tb/tb_arp_lookup_arbiter.sv
module tb_arp_lookup_arbiter;
  localparam int P_TIMEOUT  = 32;
  localparam int P_UPD_HOLD = 16;
  localparam logic [47:0] MAC_NONE = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_ip, req1_ip;
  logic [1:0]  rsp_valid;
  logic [47:0] rsp_mac;
  logic        rsp_hit;
  logic        upd_valid, upd_drop;
  logic [31:0] upd_ip;
  logic [47:0] upd_mac;
  logic [31:0] seek_ip;
  logic        seek_valid;
  logic [31:0] updata_ip;
  logic [47:0] updata_mac;
  logic        updata_valid;
  logic [47:0] active_mac;
  logic        active_valid;
  logic [31:0] arp_req_ip;
  logic        arp_req_valid;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arp_lookup_arbiter #(.P_TIMEOUT(P_TIMEOUT), .P_UPD_HOLD(P_UPD_HOLD)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .i_req0_ip(req0_ip), .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_ip(req1_ip), .o_req1_ready(req1_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_mac(rsp_mac), .o_rsp_hit(rsp_hit),
    .i_upd_valid(upd_valid), .i_upd_ip(upd_ip), .i_upd_mac(upd_mac), .o_upd_drop(upd_drop),
    .o_seek_ip(seek_ip), .o_seek_valid(seek_valid),
    .o_updata_ip(updata_ip), .o_updata_mac(updata_mac), .o_updata_valid(updata_valid),
    .i_active_mac(active_mac), .i_active_valid(active_valid),
    .o_arp_req_ip(arp_req_ip), .o_arp_req_valid(arp_req_valid),
    .o_busy(busy)
  );

  // advance one cycle; outputs are stable 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_ip = '0; req1_ip = '0;
    upd_valid = 0; upd_ip = '0; upd_mac = '0;
    active_valid = 0; active_mac = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_mac, rsp_hit, upd_drop, seek_ip, seek_valid,
         updata_ip, updata_mac, updata_valid, arp_req_ip, arp_req_valid, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rsp_valid=%b rsp_mac=%h seek_valid=%b busy=%b, expected all zero",
               rsp_valid, rsp_mac, seek_valid, busy);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int k;
    req0_valid = 1; req0_ip = 32'h0A00_0001;
    req1_valid = 1; req1_ip = 32'h0A00_0002;
    tick();
    n_cmp++;
    if ({req0_ready, req1_ready, seek_valid, seek_ip} !== {3'b101, 32'h0A00_0001}) begin
      n_bad++;
      $display("FAIL rr_first_grant: r0=%b r1=%b seek=%b ip=%h expected 1 0 1 0a000001",
               req0_ready, req1_ready, seek_valid, seek_ip);
    end
    req0_valid = 0;
    tick();
    active_valid = 1; active_mac = 48'hAAAA_BBBB_CCCC;
    tick();
    active_valid = 0;
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_mac} !== {2'b01, 1'b1, 48'hAAAA_BBBB_CCCC}) begin
      n_bad++;
      $display("FAIL rr_first_rsp: valid=%b hit=%b mac=%h expected 01 1 aaaabbbbcccc",
               rsp_valid, rsp_hit, rsp_mac);
    end
    k = 0;
    while (req1_ready !== 1'b1 && k < 6) begin tick(); k++; end
    n_cmp++;
    if (k !== 2 || req0_ready !== 1'b0 || seek_ip !== 32'h0A00_0002) begin
      n_bad++;
      $display("FAIL rr_second_grant: cycles=%0d r0=%b ip=%h expected 2 0 0a000002", k, req0_ready, seek_ip);
    end
    req1_valid = 0;
    tick();
    active_valid = 1; active_mac = MAC_NONE;
    tick();
    active_valid = 0;
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_mac} !== {2'b10, 1'b0, MAC_NONE}) begin
      n_bad++;
      $display("FAIL rr_second_rsp: valid=%b hit=%b mac=%h expected 10 0 all-ones", rsp_valid, rsp_hit, rsp_mac);
    end
`ifdef ARP_LOOKUP_ARB_MISS_REQ_EN
    n_cmp++;
    if ({arp_req_valid, arp_req_ip} !== {1'b1, 32'h0A00_0002}) begin
      n_bad++;
      $display("FAIL rr_miss_arp_req: valid=%b ip=%h expected 1 0a000002", arp_req_valid, arp_req_ip);
    end
`else
    n_cmp++;
    if (arp_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL rr_miss_arp_req: valid=%b expected 0", arp_req_valid);
    end
`endif
    tick();
    n_cmp++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rr_rsp_pulse: valid=%b busy=%b expected 00 0", rsp_valid, busy);
    end
  endtask

  task automatic test_basic_hit();
    req0_valid = 1; req0_ip = 32'hC0A8_010A;
    tick();
    n_cmp++;
    if ({req0_ready, req1_ready, seek_valid, seek_ip} !== {3'b101, 32'hC0A8_010A}) begin
      n_bad++;
      $display("FAIL basic_seek: r0=%b r1=%b seek=%b ip=%h expected 1 0 1 c0a8010a",
               req0_ready, req1_ready, seek_valid, seek_ip);
    end
    req0_valid = 0;
    tick();
    n_cmp++;
    if (req0_ready !== 1'b0 || seek_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_ready_pulse: r0=%b seek=%b expected 0 0", req0_ready, seek_valid);
    end
    tick();
    active_valid = 1; active_mac = 48'h1122_3344_5566;
    tick();
    active_valid = 0;
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_mac} !== {2'b01, 1'b1, 48'h1122_3344_5566}) begin
      n_bad++;
      $display("FAIL basic_rsp: valid=%b hit=%b mac=%h expected 01 1 112233445566", rsp_valid, rsp_hit, rsp_mac);
    end
    n_cmp++;
    if (arp_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_no_arp_req: valid=%b expected 0", arp_req_valid);
    end
    tick();
  endtask

  task automatic test_timeout();
    int k;
    req0_valid = 1; req0_ip = 32'hC0A8_0163;
    tick();
    req0_valid = 0;
    k = 0;
    while (rsp_valid === 2'b00 && k < 100) begin tick(); k++; end
    n_cmp++;
    if (k !== P_TIMEOUT + 1) begin
      n_bad++; $display("FAIL timeout_latency: cycles=%0d expected %0d", k, P_TIMEOUT + 1);
    end
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_mac} !== {2'b01, 1'b0, MAC_NONE}) begin
      n_bad++;
      $display("FAIL timeout_rsp: valid=%b hit=%b mac=%h expected 01 0 all-ones", rsp_valid, rsp_hit, rsp_mac);
    end
`ifdef ARP_LOOKUP_ARB_MISS_REQ_EN
    n_cmp++;
    if ({arp_req_valid, arp_req_ip} !== {1'b1, 32'hC0A8_0163}) begin
      n_bad++; $display("FAIL timeout_arp_req: valid=%b ip=%h expected 1 c0a80163", arp_req_valid, arp_req_ip);
    end
`else
    n_cmp++;
    if (arp_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL timeout_arp_req: valid=%b expected 0", arp_req_valid);
    end
`endif
    tick();
  endtask

  task automatic test_update_priority();
    int k;
    upd_valid = 1; upd_ip = 32'hC0A8_0105; upd_mac = 48'h0200_0000_0005;
    req0_valid = 1; req0_ip = 32'hC0A8_0106;
    tick();
    upd_valid = 0;
    n_cmp++;
    if (req0_ready !== 1'b0 || updata_valid !== 1'b0) begin
      n_bad++; $display("FAIL upd_prio_t1: r0=%b updata=%b expected 0 0", req0_ready, updata_valid);
    end
    tick();
    n_cmp++;
    if ({updata_valid, updata_ip, updata_mac, busy} !== {1'b1, 32'hC0A8_0105, 48'h0200_0000_0005, 1'b1}) begin
      n_bad++;
      $display("FAIL upd_prio_write: valid=%b ip=%h mac=%h busy=%b expected 1 c0a80105 020000000005 1",
               updata_valid, updata_ip, updata_mac, busy);
    end
    k = 0;
    while (req0_ready !== 1'b1 && k < 40) begin
      tick(); k++;
      if (k == 1) begin
        n_cmp++;
        if (updata_valid !== 1'b0) begin
          n_bad++; $display("FAIL upd_prio_pulse: updata=%b expected 0", updata_valid);
        end
      end
    end
    n_cmp++;
    if (k !== P_UPD_HOLD + 2 || seek_ip !== 32'hC0A8_0106) begin
      n_bad++;
      $display("FAIL upd_prio_hold: cycles=%0d ip=%h expected %0d c0a80106", k, seek_ip, P_UPD_HOLD + 2);
    end
    req0_valid = 0;
    tick();
    active_valid = 1; active_mac = 48'h0200_0000_0006;
    tick();
    active_valid = 0;
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_mac} !== {2'b01, 1'b1, 48'h0200_0000_0006}) begin
      n_bad++;
      $display("FAIL upd_prio_rsp: valid=%b hit=%b mac=%h expected 01 1 020000000006", rsp_valid, rsp_hit, rsp_mac);
    end
    tick();
  endtask

  task automatic test_update_drop();
    int k;
    req0_valid = 1; req0_ip = 32'hC0A8_0107;
    tick();
    req0_valid = 0;
    tick();
    upd_valid = 1; upd_ip = 32'h0A0A_0A01; upd_mac = 48'h0000_0000_00A1;
    tick();
    upd_ip = 32'h0A0A_0A02; upd_mac = 48'h0000_0000_00B2;
    n_cmp++;
    if (upd_drop !== 1'b0) begin n_bad++; $display("FAIL drop_first: drop=%b expected 0", upd_drop); end
    tick();
    upd_valid = 0;
    n_cmp++;
    if (upd_drop !== 1'b1) begin n_bad++; $display("FAIL drop_second: drop=%b expected 1", upd_drop); end
    active_valid = 1; active_mac = 48'h0000_0000_0007;
    tick();
    active_valid = 0;
    n_cmp++;
    if (upd_drop !== 1'b0 || rsp_valid !== 2'b01) begin
      n_bad++; $display("FAIL drop_pulse_rsp: drop=%b rsp=%b expected 0 01", upd_drop, rsp_valid);
    end
    k = 0;
    while (updata_valid !== 1'b1 && k < 10) begin tick(); k++; end
    n_cmp++;
    if ({k[3:0], updata_ip, updata_mac} !== {4'd2, 32'h0A0A_0A02, 48'h0000_0000_00B2}) begin
      n_bad++;
      $display("FAIL drop_written_pair: cycles=%0d ip=%h mac=%h expected 2 0a0a0a02 0000000000b2",
               k, updata_ip, updata_mac);
    end
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      tick(); k++;
      if (updata_valid === 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL drop_single_write: updata=1 expected 0 after %0d cycles", k);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_return_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_in_wait();
    int k;
    req0_valid = 1; req0_ip = 32'hC0A8_0108;
    tick();
    req0_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    active_valid = 1; active_mac = 48'h0000_0000_0008;
    n_cmp++;
    if ({busy, rsp_valid, seek_valid, seek_ip, rsp_mac, req0_ready} !== '0) begin
      n_bad++;
      $display("FAIL rst_wait_outputs: busy=%b rsp=%b seek=%b ip=%h mac=%h expected all zero",
               busy, rsp_valid, seek_valid, seek_ip, rsp_mac);
    end
    tick();
    active_valid = 0;
    tick();
    n_cmp++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_wait_late_rsp: rsp=%b busy=%b expected 00 0", rsp_valid, busy);
    end
    req0_valid = 1; req0_ip = 32'hC0A8_0109;
    tick();
    req0_valid = 0;
    n_cmp++;
    if (req0_ready !== 1'b1 || seek_ip !== 32'hC0A8_0109) begin
      n_bad++; $display("FAIL rst_wait_fresh_seek: r0=%b ip=%h expected 1 c0a80109", req0_ready, seek_ip);
    end
    tick(); tick();
    active_valid = 1; active_mac = 48'h0000_0000_0009;
    tick();
    active_valid = 0;
    k = 0;
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_mac} !== {2'b01, 1'b1, 48'h0000_0000_0009}) begin
      n_bad++;
      $display("FAIL rst_wait_fresh_rsp: valid=%b hit=%b mac=%h expected 01 1 000000000009", rsp_valid, rsp_hit, rsp_mac);
    end
    tick();
  endtask

  initial begin
    #2;
    test_reset();
    test_round_robin();
    test_basic_hit();
    test_timeout();
    test_update_priority();
    test_update_drop();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
